// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - word-indexed data memory bus between the access unit and the memory
interface mem_access_unit_if;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [31:0] dm_read_data;

    modport master (
        output dm_address, dm_write_data, dm_mem_read, dm_mem_write,
        input  dm_read_data
    );

    modport slave (
        input  dm_address, dm_write_data, dm_mem_read, dm_mem_write,
        output dm_read_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store unit with RMW sub-word stores; ALIGN_CHECK_EN drops misaligned requests
module mem_access_unit #(
    parameter int DEPTH_WORDS = 100,
    parameter int BIG_ENDIAN  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic [1:0]          size_i,
    input  logic                unsigned_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    output logic                busy_o,
    output logic [31:0]         load_data_o,
    output logic                load_valid_o,
    output logic                misalign_o,
    output logic                addr_err_o,
    mem_access_unit_if.master   dm
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR} state_t;

    localparam logic [29:0] DepthW = 30'(DEPTH_WORDS);
    localparam bit          BigEnd = (BIG_ENDIAN != 0);

    state_t      state_q, state_d;
    logic        ld_wait_q, ld_wait_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        misalign_q, misalign_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic        dm_rd_q, dm_rd_d;
    logic        dm_wr_q, dm_wr_d;

    logic        reject_mis;
    logic        range_err;
    logic [1:0]  req_off;
    logic [1:0]  lane;
    logic [4:0]  sh;
    logic [31:0] rd_shifted;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic [31:0] extended;

    // Requests are forced to natural alignment; with the check enabled a
    // misaligned request is rejected before this offset is ever used.
    always_comb begin
        req_off = 2'b00;
        case (size_i)
            2'b00:   req_off = addr_i[1:0];
            2'b01:   req_off = {addr_i[1], 1'b0};
            default: req_off = 2'b00;
        endcase
    end

`ifdef ALIGN_CHECK_EN
    always_comb begin
        reject_mis = 1'b0;
        case (size_i)
            2'b00:   reject_mis = 1'b0;
            2'b01:   reject_mis = addr_i[0];
            default: reject_mis = (addr_i[1:0] != 2'b00);
        endcase
    end
`else
    assign reject_mis = 1'b0;
`endif

    assign range_err = (addr_i[31:2] >= DepthW);

    // Lane index counts from bit 0; big-endian mirrors the byte offset.
    always_comb begin
        lane = 2'b00;
        case (size_q)
            2'b00:   lane = BigEnd ? ~off_q : off_q;
            2'b01:   lane = BigEnd ? {~off_q[1], 1'b0} : {off_q[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

    assign sh         = {lane, 3'b000};
    assign rd_shifted = dm.dm_read_data >> sh;

    always_comb begin
        lane_mask = 32'hFFFF_FFFF;
        extended  = dm.dm_read_data;
        case (size_q)
            2'b00: begin
                lane_mask = 32'h0000_00FF << sh;
                extended  = {{24{~uns_q & rd_shifted[7]}}, rd_shifted[7:0]};
            end
            2'b01: begin
                lane_mask = 32'h0000_FFFF << sh;
                extended  = {{16{~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                extended  = dm.dm_read_data;
            end
        endcase
    end

    assign merged = (dm.dm_read_data & ~lane_mask) | ((wdata_q << sh) & lane_mask);

    always_comb begin
        state_d      = state_q;
        ld_wait_d    = ld_wait_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        busy_d       = busy_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misalign_d   = 1'b0;
        addr_err_d   = 1'b0;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        dm_rd_d      = dm_rd_q;
        dm_wr_d      = dm_wr_q;

        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                dm_rd_d = 1'b0;
                dm_wr_d = 1'b0;
                if (mem_read_i || mem_write_i) begin
                    if (reject_mis) begin
                        misalign_d = 1'b1;
                    end else if (range_err) begin
                        addr_err_d = 1'b1;
                    end else begin
                        off_d     = req_off;
                        size_d    = size_i;
                        uns_d     = unsigned_i;
                        wdata_d   = wdata_i;
                        dm_addr_d = {2'b00, addr_i[31:2]};
                        busy_d    = 1'b1;
                        if (mem_write_i) begin
                            if (size_i[1]) begin
                                state_d    = WRITE;
                                dm_wr_d    = 1'b1;
                                dm_wdata_d = wdata_i;
                            end else begin
                                state_d = RMW_RD;
                                dm_rd_d = 1'b1;
                            end
                        end else begin
                            state_d   = LOAD;
                            dm_rd_d   = 1'b1;
                            ld_wait_d = 1'b1;
                        end
                    end
                end
            end
            // LOAD spans two cycles so the result is registered on the
            // second edge after the request was sampled.
            LOAD: begin
                if (ld_wait_q) begin
                    ld_wait_d = 1'b0;
                end else begin
                    load_data_d  = extended;
                    load_valid_d = 1'b1;
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    dm_rd_d      = 1'b0;
                end
            end
            WRITE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                dm_wr_d = 1'b0;
            end
            RMW_RD: begin
                dm_wdata_d = merged;
                dm_rd_d    = 1'b0;
                dm_wr_d    = 1'b1;
                state_d    = RMW_WR;
            end
            RMW_WR: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                dm_wr_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                dm_rd_d = 1'b0;
                dm_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ld_wait_q    <= 1'b0;
            off_q        <= 2'b00;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= 32'h0;
            busy_q       <= 1'b0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            addr_err_q   <= 1'b0;
            dm_addr_q    <= 32'h0;
            dm_wdata_q   <= 32'h0;
            dm_rd_q      <= 1'b0;
            dm_wr_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_wait_q    <= ld_wait_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misalign_q   <= misalign_d;
            addr_err_q   <= addr_err_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            dm_rd_q      <= dm_rd_d;
            dm_wr_q      <= dm_wr_d;
        end
    end

    assign busy_o           = busy_q;
    assign load_data_o      = load_data_q;
    assign load_valid_o     = load_valid_q;
    assign misalign_o       = misalign_q;
    assign addr_err_o       = addr_err_q;
    assign dm.dm_address    = dm_addr_q;
    assign dm.dm_write_data = dm_wdata_q;
    assign dm.dm_mem_read   = dm_rd_q;
    assign dm.dm_mem_write  = dm_wr_q;

endmodule
